// File: rtl/rr_arb_mux.sv
// Registered N:1 round-robin arbitrating multiplexer with valid/ready on every channel.
// Define RR_ARB_MUX_LOCK_EN to hold a grant across a multi-beat packet (terminated by in_last).
module rr_arb_mux #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 32,
  parameter int unsigned SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  output logic           out_last
);

  logic [SW-1:0] ptr_q;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic [SW-1:0] out_sel_q;

  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] ptr_inc;
  logic          gnt_any;
  logic          load;
  logic          accept;
  logic          advance;
  int unsigned   idx;

`ifdef RR_ARB_MUX_LOCK_EN
  logic          locked_q;
  logic [SW-1:0] lock_ch_q;
  logic          out_last_q;
`endif

  // Scan ptr, ptr+1, ... wrapping modulo N so non-power-of-2 N never selects a ghost channel.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_q) + k) % N;
      if (!gnt_any && in_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'(idx);
      end
    end
`ifdef RR_ARB_MUX_LOCK_EN
    if (locked_q) begin
      gnt_any = in_valid[lock_ch_q];
      gnt_idx = lock_ch_q;
    end
`endif
  end

  assign ptr_inc = SW'((32'(gnt_idx) + 1) % N);
  assign load    = !out_valid_q || out_ready;
  assign accept  = gnt_any && load;

`ifdef RR_ARB_MUX_LOCK_EN
  assign advance = in_last[gnt_idx];
`else
  assign advance = 1'b1;
  logic unused_last;
  assign unused_last = ^in_last;
`endif

  always_comb begin
    in_ready = '0;
    if (accept && reset_n) in_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_data_q  <= in_data[32'(gnt_idx)*W +: W];
      out_sel_q   <= gnt_idx;
      if (advance) ptr_q <= ptr_inc;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef RR_ARB_MUX_LOCK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      locked_q   <= 1'b0;
      lock_ch_q  <= '0;
      out_last_q <= 1'b0;
    end else if (accept) begin
      locked_q   <= !in_last[gnt_idx];
      lock_ch_q  <= gnt_idx;
      out_last_q <= in_last[gnt_idx];
    end
  end
  assign out_last = out_last_q;
`else
  assign out_last = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed self-checking bench for rr_arb_mux (N=4, W=32).
// Lock scenarios follow RR_ARB_MUX_LOCK_EN when it is defined for the build.
module tb_rr_arb_mux;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned SW = 2;

  logic           clk;
  logic           reset_n;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_last;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_last;

  int nvec;
  int nerr;

  rr_arb_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    #2;
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b0;
    #3;
    nvec++;
    if ({out_valid, out_data, out_sel, out_last, in_ready} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%0d l=%b r=%b want all zero",
               out_valid, out_data, out_sel, out_last, in_ready);
    end
    #4;
    reset_n = 1'b1;
    tick();
    nvec++;
    if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_idle: got r=%b v=%b want r=0000 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_round_robin;
    for (int i = 0; i < 4; i++) in_data[i*W +: W] = 32'hA0 + i;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL rr_first_ready: got %b want 0001", in_ready);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      nvec++;
      if (out_valid !== 1'b1 || out_sel !== SW'(k % 4) || out_data !== 32'hA0 + (k % 4)) begin
        nerr++;
        $display("FAIL rr_beat%0d: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 k, out_valid, out_sel, out_data, k % 4, 32'hA0 + (k % 4));
      end
      nvec++;
      if (in_ready !== 4'(1 << ((k + 1) % 4))) begin
        nerr++;
        $display("FAIL rr_ready%0d: got %b want %b", k, in_ready, 4'(1 << ((k + 1) % 4)));
      end
    end
    in_valid = '0;
    tick();
    nvec++;
    if (out_valid !== 1'b0 || out_data !== 32'hA0 || out_sel !== 2'd0) begin
      nerr++;
      $display("FAIL rr_drain: got v=%b d=%h s=%0d want v=0 d=a0 s=0",
               out_valid, out_data, out_sel);
    end
  endtask

  // Pointer is 1 on entry (last grant went to channel 0).
  task automatic test_backpressure;
    in_data[2*W +: W] = 32'h1234;
    in_data[3*W +: W] = 32'h3333;
    in_valid = 4'b0100;
    #1;
    nvec++;
    if (in_ready !== 4'b0100) begin
      nerr++;
      $display("FAIL bp_ready_ch2: got %b want 0100", in_ready);
    end
    tick();
    in_valid  = 4'b1011;
    out_ready = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      nvec++;
      if (out_valid !== 1'b1 || out_data !== 32'h1234 || out_sel !== 2'd2 || in_ready !== 4'b0000) begin
        nerr++;
        $display("FAIL bp_hold%0d: got v=%b d=%h s=%0d r=%b want v=1 d=1234 s=2 r=0000",
                 c, out_valid, out_data, out_sel, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b1000) begin
      nerr++;
      $display("FAIL bp_release_ready: got %b want 1000", in_ready);
    end
    tick();
    nvec++;
    if (out_sel !== 2'd3 || out_data !== 32'h3333 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL bp_next_grant: got s=%0d d=%h v=%b want s=3 d=3333 v=1",
               out_sel, out_data, out_valid);
    end
    in_valid = '0;
    tick();
  endtask

  // Pointer is 0 on entry.
  task automatic test_sparse;
    in_valid = 4'b0010;
    tick();
    in_valid = 4'b1010;
    #1;
    nvec++;
    if (in_ready !== 4'b1000) begin
      nerr++;
      $display("FAIL sparse_first: got %b want 1000", in_ready);
    end
    tick();
    nvec++;
    if (out_sel !== 2'd3 || in_ready !== 4'b0010) begin
      nerr++;
      $display("FAIL sparse_ch3: got s=%0d r=%b want s=3 r=0010", out_sel, in_ready);
    end
    tick();
    in_valid = '0;
    nvec++;
    if (out_sel !== 2'd1 || out_valid !== 1'b1) begin
      nerr++;
      $display("FAIL sparse_ch1: got s=%0d v=%b want s=1 v=1", out_sel, out_valid);
    end
    tick();
    nvec++;
    if (out_valid !== 1'b0 || out_sel !== 2'd1) begin
      nerr++;
      $display("FAIL sparse_idle: got v=%b s=%0d want v=0 s=1", out_valid, out_sel);
    end
  endtask

  task automatic test_packet;
    logic [SW-1:0] exp_sel [4];
    logic          exp_last[3];
    do_reset();
`ifdef RR_ARB_MUX_LOCK_EN
    exp_sel  = '{2'd0, 2'd0, 2'd0, 2'd1};
    exp_last = '{1'b0, 1'b0, 1'b1};
`else
    exp_sel  = '{2'd0, 2'd1, 2'd0, 2'd1};
    exp_last = '{1'b0, 1'b0, 1'b0};
`endif
    out_ready = 1'b1;
    in_valid  = 4'b0011;
    in_last   = 4'b0010;
    in_data[0 +: W] = 32'hB0;
    in_data[W +: W] = 32'hC0;
    for (int b = 0; b < 4; b++) begin
      tick();
      nvec++;
      if (out_sel !== exp_sel[b] || out_valid !== 1'b1) begin
        nerr++;
        $display("FAIL pkt_sel%0d: got s=%0d v=%b want s=%0d v=1", b, out_sel, out_valid, exp_sel[b]);
      end
      if (b < 3) begin
        nvec++;
        if (out_last !== exp_last[b]) begin
          nerr++;
          $display("FAIL pkt_last%0d: got %b want %b", b, out_last, exp_last[b]);
        end
      end
`ifdef RR_ARB_MUX_LOCK_EN
      in_data[0 +: W] = 32'hB0 + b + 1;
      in_last[0]      = (b == 1);
`endif
    end
    in_valid = '0;
    in_last  = '0;
    tick();
  endtask

  task automatic test_async_reset;
    do_reset();
    in_valid  = 4'b0010;
    in_last   = 4'b0000;
    out_ready = 1'b0;
    tick();
    in_valid = 4'b0011;
    #2;
    reset_n = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== '0 || in_ready !== 4'b0000) begin
      nerr++;
      $display("FAIL areset_clear: got v=%b d=%h s=%0d r=%b want all zero",
               out_valid, out_data, out_sel, in_ready);
    end
    #2;
    reset_n   = 1'b1;
    out_ready = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 4'b0001) begin
      nerr++;
      $display("FAIL areset_priority: got %b want 0001", in_ready);
    end
    tick();
    nvec++;
    if (out_sel !== 2'd0 || out_valid !== 1'b1 || in_ready !== 4'b0010) begin
      nerr++;
      $display("FAIL areset_first: got s=%0d v=%b r=%b want s=0 v=1 r=0010",
               out_sel, out_valid, in_ready);
    end
    in_valid = '0;
    tick();
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_packet();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Registered N-channel, W-bit round-robin arbitrating multiplexer with valid/ready handshakes on every channel. It is the parametrised, sequential successor to the team's fixed 4:1 bit multiplexers. It merges several producer streams (e.g. fetch/load/store request queues) onto one consumer port in the pipeline. Arbitration is fair and per-beat, and an optional packet lock holds a grant for a whole multi-beat transfer.

## Interface
- `N`, 4: number of input channels, 1..16.
- `W`, 32: data width in bits, ≥1.
- `SW`, `$clog2(N)` (min 1): width of the channel index.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `in_valid` in N: per-channel request; bit i belongs to channel i.
- `in_last` in N: per-channel end-of-packet flag. Used only with `RR_ARB_MUX_LOCK_EN`.
- `in_data` in N*W: channel i occupies bits [i*W +: W].
- `in_ready` out N: per-channel accept, one-hot or zero.
- `out_valid` out 1: output register holds a beat.
- `out_ready` in 1: consumer accepts the beat.
- `out_data` out W: registered data.
- `out_sel` out SW: index of the channel that supplied `out_data`.
- `out_last` out 1: registered `in_last` of the accepted beat (0 without the macro).

## Operation
- The block has one output register (`out_valid`, `out_data`, `out_sel`, `out_last`) and a priority pointer `ptr` (SW bits).
- `load = !out_valid || out_ready`.
- Grant: the first channel with `in_valid` set, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N, correct for non-power-of-2 N).
- `in_ready[g] = load` for the granted channel g. All other `in_ready` bits are 0.
  - `in_ready` depends combinationally on `out_ready` and `in_valid`.
  - It never depends on `in_data`.
- Accept (`in_valid[g] && in_ready[g]`):
  - Next edge: `out_data <= in_data[g]`, `out_sel <= g`, `out_valid <= 1`.
  - `ptr <= (g+1) mod N`.
- No accept and `out_ready` high: `out_valid <= 0`. `out_data`, `out_sel` and `out_last` hold.
- Stall (`out_valid && !out_ready`): all output registers hold, `in_ready` is all zero, `ptr` holds.
- Simultaneous drain and accept is a full-throughput case: one beat per cycle, no bubble.
- `in_valid` all zero: no grant, `ptr` holds.
- N=1: `ptr` stays 0 and the block degenerates to a one-stage pipeline register.

## Timing
- Latency: 1 cycle from input accept to `out_valid`.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Reset values: `out_valid=0`, `out_data=0`, `out_sel=0`, `out_last=0`, `ptr=0` (channel 0 has first priority after reset).
- Reset asserted mid-transfer:
  - All registers clear immediately, asynchronously.
  - Any held beat is discarded.
  - Any lock is released.
  - `in_ready` goes to 0 while `reset_n` is low.
- The first accept is possible on the first rising edge after `reset_n` deasserts.
- Handshake rules, required of producers and provided by this block at its output:
  - Once valid is high it stays high with data stable until accepted.
  - Ready may toggle freely.

## Configuration
- `RR_ARB_MUX_LOCK_EN` defined: packet lock is enabled.
  - Accepting a beat with `in_last[g]=0` sets `locked=1` and `lock_ch=g`.
  - While locked, only `lock_ch` can be granted, and `ptr` does not advance.
  - Accepting a beat with `in_last=1` clears `locked` and sets `ptr <= (lock_ch+1) mod N`.
  - `out_last` registers `in_last[g]`.
  - `locked` and `lock_ch` reset to 0.
- Macro undefined:
  - `in_last` is ignored and `out_last` is tied to 0.
  - Arbitration rotates every beat.
  - No lock state is synthesised.

## Test plan
- Reset then idle:
  - Required after `reset_n` low: all outputs 0.
  - Required after release: `in_ready=0` while `in_valid=0`.
- N=4, W=32, all channels valid with data 0xA0+i, `out_ready=1`:
  - `out_sel` sequence is 0,1,2,3,0 on consecutive cycles.
  - `out_data` follows 0xA0..0xA3.
  - No bubbles.
- Backpressure:
  - Beat 0x1234 from channel 2 is held with `out_ready=0` for 3 cycles.
  - `out_data`/`out_sel` stay at 0x1234/2 and `in_ready=0` throughout.
  - On release, the next grant goes to channel 3.
- Sparse requests:
  - Only channels 1 and 3 valid, `ptr=2`: grant channel 3 first, then channel 1.
  - Then all channels idle: `out_valid` drops one cycle after the last drain.
- With `RR_ARB_MUX_LOCK_EN`:
  - Channel 0 sends 3 beats with `in_last` = 0,0,1 while channel 1 is valid throughout.
  - Channel 0 gets all 3 consecutive grants, then channel 1.
  - `out_last` = 0,0,1,x.
- Async reset asserted while `out_valid=1` and locked:
  - `out_valid` drops immediately, without waiting for a clock edge.
  - After release, channel 0 has priority and the lock is cleared.
